logc_mc: RTL and testbench
==========================

Name: logc_mc

Overview:
Multi-channel, fully handshaked log-compression pipeline for the envelope-to-display path. It converts unsigned envelope-power samples into display codes: OUT_WIDTH = clamp((log2(x)·gain) − offset).
- Successor to the single-channel, always-valid log compressor.
- Adds channel tagging, real valid/ready backpressure, optional log-error correction, runtime gain/offset latched per frame, and a clip counter.
- Sits between the envelope detector and scan conversion.

Parameters:
- DATA_WIDTH, 48, input sample width (unsigned).
- CHANNELS, 8, number of time-interleaved channels carried by the tag.
- CH_WIDTH, $clog2(CHANNELS), channel-tag width.
- FRAC_WIDTH, 8, fractional bits of log2 result.
- EXP_WIDTH, $clog2(DATA_WIDTH), integer bits of log2 result.
- LOG_WIDTH, EXP_WIDTH+FRAC_WIDTH+1, internal log width (one guard bit for correction carry).
- GAIN_WIDTH, 12, unsigned gain, GAIN_FRAC fractional bits.
- GAIN_FRAC, 8, gain binary point.
- OUT_WIDTH, 8, display code width.
- MIN_THRESHOLD, 0, samples ≤ this value are floored.
- CNT_WIDTH, 16, clip-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  envelope power.
- in_ch  in  CH_WIDTH  channel tag.
- in_first  in  1  first sample of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  OUT_WIDTH  display code.
- out_ch  out  CH_WIDTH  channel tag, passed through.
- out_first  out  1  in_first, passed through.
- out_clip  out  1  this result was clamped high.
- cfg_gain  in  GAIN_WIDTH  gain, unsigned Q(GAIN_WIDTH−GAIN_FRAC).GAIN_FRAC.
- cfg_offset  in  LOG_WIDTH+1  offset in output LSBs, signed.
- cfg_corr_en  in  1  enable log-error correction LUT.
- clip_count  out  CNT_WIDTH  clipped results in current frame; saturates.

Behaviour:
- Reset values (clk and reset as named above; reset is synchronous, active-high):
  - All stage valids 0, so out_valid 0.
  - out_data, out_ch, out_first, out_clip all 0; clip_count 0.
  - Shadow config: gain = 1<<GAIN_FRAC, offset 0, corr 0.
- Pipeline and handshake:
  - Four register stages, latency exactly 4 cycles from accept to out_valid when unstalled.
  - Global advance = !out_valid || out_ready.
  - in_ready = advance, purely combinational from out_valid/out_ready.
  - All stages shift together on advance and hold otherwise.
  - No sample is ever dropped or duplicated.
  - Throughput is 1 sample/cycle while out_ready is held high.
- Config shadowing:
  - On an accepted beat with in_first=1, cfg_gain, cfg_offset and cfg_corr_en are latched into shadow registers that travel with that sample.
  - That sample and all later samples use the new shadow values.
  - Config changes without in_first have no effect.
- S1, normalise:
  - e = index of leading one of in_data.
  - m = the FRAC_WIDTH bits directly below the leading one, left-aligned and zero-padded when e < FRAC_WIDTH.
  - floor flag = (in_data ≤ MIN_THRESHOLD) || (in_data == 0).
- S2, log:
  - L = e·2^FRAC_WIDTH + m (Mitchell approximation).
  - If corr enabled, add LOGC_CORR[m[FRAC_WIDTH−1 -: 4]].
  - If floor, L = 0.
- S3, scale: S = (L·gain) >> GAIN_FRAC, truncated, full-width product.
- S4, offset and clamp:
  - V = S − offset, signed.
  - If V < 0, out 0.
  - If V > 2^OUT_WIDTH−1, out = 2^OUT_WIDTH−1 and out_clip = 1.
  - Floored samples always give out 0 with out_clip 0.
- clip_count:
  - Cleared on the out-accept (out_valid && out_ready) of an out_first beat, then counts that beat's clip.
  - Increments on every other accepted clipped beat.
  - Saturates at all-ones.
- Reset mid-stream: in-flight samples are discarded, out_valid is 0 the cycle after reset, and there is no partial output.
- Simultaneous in_first accept and out_first output: each acts on its own stage, with no interaction.

Decomposition:
- Package logc_pkg holds:
  - LOGC_CORR[16], with entry k = round(256·(log2(1+(k+0.5)/16) − (k+0.5)/16)), scaled by 2^(FRAC_WIDTH−8).
  - Default config constants.
  - A struct for the per-stage payload: data, ch, first, floor, clip, shadow cfg.
- One natural sub-module: logc_lod, a parametrised leading-one detector that returns e and m, used in S1.

Test Plan:
- gain=256, offset=0, corr=0; in_data=1 → out_data=0 after 4 cycles, out_clip=0.
- in_data=2^10, gain=256, offset=2500 → L=2560, out_data=60.
- in_data=3, gain=64, offset=0:
  - corr=0 → L=384, out_data=96.
  - corr=1 → LOGC_CORR[8]=21, L=405, out_data=101.
- in_data=2^40, gain=256, offset=0 → out_data=255, out_clip=1; clip_count reads 1 within a frame started by in_first.
- Stream 20 samples on ch 0..7 with out_ready low cycles 5–14 → in_ready falls with out_ready, output order and tags match input exactly, no loss.
- Set gain=128 mid-frame → no effect until the next in_first beat. Assert reset during the stream → out_valid=0 and clip_count=0 on the next cycle.

Source files
------------

// File: rtl/logc_pkg.sv
// logc_pkg: shared widths, default config, correction table and stage payload for logc_mc
package logc_pkg;
  localparam int DATA_W = 48;
  localparam int CH_W = 3;
  localparam int FRAC_W = 8;
  localparam int EXP_W = 6;
  localparam int LOG_W = EXP_W + FRAC_W + 1;
  localparam int GAIN_W = 12;
  localparam int GAIN_FR = 8;
  localparam int OUT_W = 8;
  localparam int CNT_W = 16;
  localparam int PAY_W = LOG_W + GAIN_W - GAIN_FR;
  localparam logic [GAIN_W-1:0] GAIN_DEF = GAIN_W'(1 << GAIN_FR);
  localparam logic [LOG_W:0] OFFSET_DEF = '0;
  localparam logic CORR_DEF = 1'b0;
  localparam logic [7:0] LOGC_CORR [16] = '{
    8'd3, 8'd9, 8'd14, 8'd17, 8'd20, 8'd21, 8'd22, 8'd22,
    8'd21, 8'd20, 8'd18, 8'd16, 8'd13, 8'd10, 8'd6, 8'd2
  };
  typedef struct packed {
    logic [PAY_W-1:0] data;
    logic [CH_W-1:0] ch;
    logic first;
    logic floor;
    logic clip;
    logic [GAIN_W-1:0] gain;
    logic [LOG_W:0] offset;
    logic corr;
  } pay_t;
  function automatic logic [PAY_W-1:0] corr_lut(input logic [3:0] k);
    return PAY_W'(LOGC_CORR[k]) << (FRAC_W - 8);
  endfunction
endpackage

// File: rtl/logc_lod.sv
// logc_lod: leading-one index and the left-aligned bits just below it
module logc_lod #(
  parameter int DW = 48,
  parameter int EW = 6,
  parameter int FW = 8
) (
  input  logic [DW-1:0] x,
  output logic [EW-1:0] e,
  output logic [FW-1:0] m
);
  always_comb begin
    e = '0;
    for (int i = 0; i < DW; i++)
      if (x[i]) e = EW'(i);
    m = FW'({x, {FW{1'b0}}} >> e);
  end
endmodule

// File: rtl/logc_mc.sv
// logc_mc: four-stage handshaked log compressor, per-frame config shadowing and clip counting
module logc_mc
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int CHANNELS = 8,
  parameter int CH_WIDTH = $clog2(CHANNELS),
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int EXP_WIDTH = $clog2(DATA_WIDTH),
  parameter int LOG_WIDTH = EXP_WIDTH + FRAC_WIDTH + 1,
  parameter int GAIN_WIDTH = GAIN_W,
  parameter int GAIN_FRAC = GAIN_FR,
  parameter int OUT_WIDTH = OUT_W,
  parameter logic [DATA_WIDTH-1:0] MIN_THRESHOLD = '0,
  parameter int CNT_WIDTH = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_WIDTH-1:0]   in_ch,
  input  logic                  in_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [CH_WIDTH-1:0]   out_ch,
  output logic                  out_first,
  output logic                  out_clip,
  input  logic [GAIN_WIDTH-1:0] cfg_gain,
  input  logic [LOG_WIDTH:0]    cfg_offset,
  input  logic                  cfg_corr_en,
  output logic [CNT_WIDTH-1:0]  clip_count
);
  localparam logic signed [PAY_W+1:0] VMAX = (PAY_W+2)'((1 << OUT_WIDTH) - 1);
  logic [3:0] vld;
  pay_t st [4];
  pay_t n [4];
  logic [GAIN_WIDTH-1:0] sh_gain;
  logic [LOG_WIDTH:0] sh_off;
  logic sh_corr;
  logic [EXP_WIDTH-1:0] e;
  logic [FRAC_WIDTH-1:0] m;
  logic [PAY_W+GAIN_WIDTH-1:0] prod;
  logic signed [PAY_W+1:0] vv;
  logic advance;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign out_valid = vld[3];
  assign out_data = st[3].data[OUT_WIDTH-1:0];
  assign out_ch = st[3].ch;
  assign out_first = st[3].first;
  assign out_clip = st[3].clip;
  logc_lod #(.DW(DATA_WIDTH), .EW(EXP_WIDTH), .FW(FRAC_WIDTH)) u_lod (.x(in_data), .e(e), .m(m));
  always_comb begin
    n[0] = '0;
    n[0].data = PAY_W'({e, m});
    n[0].ch = in_ch;
    n[0].first = in_first;
    n[0].floor = (in_data <= MIN_THRESHOLD) || (in_data == '0);
    n[0].gain = in_first ? cfg_gain : sh_gain;
    n[0].offset = in_first ? cfg_offset : sh_off;
    n[0].corr = in_first ? cfg_corr_en : sh_corr;
    n[1] = st[0];
    n[1].data = st[0].floor ? '0 : st[0].data + (st[0].corr ? corr_lut(st[0].data[FRAC_WIDTH-1 -: 4]) : '0);
    n[2] = st[1];
    prod = {{GAIN_WIDTH{1'b0}}, st[1].data} * {{PAY_W{1'b0}}, st[1].gain};
    n[2].data = PAY_W'(prod >> GAIN_FRAC);
    n[3] = st[2];
    vv = $signed({2'b00, st[2].data}) - $signed({{(PAY_W+1-LOG_WIDTH){st[2].offset[LOG_WIDTH]}}, st[2].offset});
    n[3].clip = !st[2].floor && (vv > VMAX);
    n[3].data = (st[2].floor || vv < 0) ? '0 : n[3].clip ? PAY_W'(VMAX) : PAY_W'(vv);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      st <= '{default: '0};
      sh_gain <= GAIN_DEF;
      sh_off <= OFFSET_DEF;
      sh_corr <= CORR_DEF;
      clip_count <= '0;
    end else begin
      if (advance) begin
        vld <= {vld[2:0], in_valid};
        st <= n;
      end
      if (in_valid && advance && in_first) begin
        sh_gain <= cfg_gain;
        sh_off <= cfg_offset;
        sh_corr <= cfg_corr_en;
      end
      // a frame's first result restarts the count with its own clip
      if (out_valid && out_ready)
        clip_count <= out_first ? CNT_WIDTH'(out_clip) :
                      (out_clip && !(&clip_count)) ? clip_count + 1'b1 : clip_count;
    end
  end
endmodule

// File: tb/tb_logc_mc.sv
// tb_logc_mc: directed stimulus checked against an arithmetic log-compression model
module tb_logc_mc;
  logic clk = 0, reset = 1, in_valid = 0, in_first = 0, out_ready = 1, cfg_corr_en = 0;
  logic in_ready, out_valid, out_first, out_clip;
  logic [47:0] in_data = '0;
  logic [2:0] in_ch = '0, out_ch;
  logic [7:0] out_data;
  logic [11:0] cfg_gain = 12'd256;
  logic [15:0] cfg_offset = '0, clip_count;
  typedef struct {int d; int ch; bit f; bit c;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, nout = 0, last_out = -1, last_clip = -1;
  longint mcnt = 0, sg = 256, so = 0;
  bit sc = 0;
  int ct [16] = '{3, 9, 14, 17, 20, 21, 22, 22, 21, 20, 18, 16, 13, 10, 6, 2};

  logc_mc dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .in_first(in_first), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_first(out_first), .out_clip(out_clip), .cfg_gain(cfg_gain),
    .cfg_offset(cfg_offset), .cfg_corr_en(cfg_corr_en), .clip_count(clip_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // returns code | clip<<8
  function automatic int mdl(input longint x, input longint g, input longint off, input bit c);
    longint e = 0, m, l, s, v;
    if (x == 0) return 0;
    for (int i = 0; i < 48; i++) if (((x >> i) & 1) == 1) e = i;
    m = ((x - (longint'(1) << e)) << 8) >> e;
    l = e * 256 + m + (c ? longint'(ct[m >> 4]) : 0);
    s = (l * g) >> 8;
    v = s - off;
    return v < 0 ? 0 : v > 255 ? 511 : int'(v);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    int r;
    if (reset) begin
      q.delete();
      mcnt = 0; sg = 256; so = 0; sc = 0;
    end else begin
      chk("clip_count", clip_count, mcnt);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_output", 1, 0);
        else begin
          x = q.pop_front();
          chk("out_data", out_data, x.d);
          chk("out_ch", out_ch, x.ch);
          chk("out_first", out_first, x.f);
          chk("out_clip", out_clip, x.c);
          if (x.f) mcnt = x.c;
          else if (x.c && mcnt != 65535) mcnt++;
        end
        last_out = out_data; last_clip = out_clip; nout++;
      end
      if (in_valid && in_ready) begin
        if (in_first) begin sg = cfg_gain; so = longint'($signed(cfg_offset)); sc = cfg_corr_en; end
        r = mdl(longint'(in_data), sg, so, sc);
        q.push_back('{r & 255, int'(in_ch), in_first, r > 255});
      end
    end
  end

  task automatic send(input logic [47:0] x, input int ch, input bit f, input int g, input int off, input bit c);
    bit ok = 0;
    in_data = x; in_ch = 3'(ch); in_first = f; cfg_gain = 12'(g); cfg_offset = 16'(off); cfg_corr_en = c;
    in_valid = 1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain;
    int k = 0;
    while (k < 100 && (q.size() != 0 || out_valid)) begin
      @(posedge clk); #1; k++;
    end
    if (k == 100) chk("drain_timeout", 0, 1);
  endtask

  task automatic one(input string nm, input logic [47:0] x, input bit f, input int g, input int off,
                     input bit c, input int exp_d, input int exp_c);
    send(x, 1, f, g, off, c);
    drain();
    chk({nm, "_data"}, last_out, exp_d);
    chk({nm, "_clip"}, last_clip, exp_c);
  endtask

  initial begin
    int n, base;
    chk("pin_1024", mdl(1024, 256, 2500, 0), 60);
    chk("pin_3", mdl(3, 64, 0, 0), 96);
    chk("pin_3_corr", mdl(3, 64, 0, 1), 101);
    chk("pin_2p40", mdl(longint'(1) << 40, 256, 0, 0), 511);
    chk("pin_1", mdl(1, 256, 0, 0), 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_clip", out_clip, 0);
    chk("rst_clip_count", clip_count, 0);
    send(1, 0, 1, 256, 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 3);
    drain();
    chk("one_data", last_out, 0);
    one("log1024", 1024, 1, 256, 2500, 0, 60, 0);
    one("three", 3, 1, 64, 0, 0, 96, 0);
    one("three_corr", 3, 1, 64, 0, 1, 101, 0);
    one("big", 48'h1 << 40, 1, 256, 0, 0, 255, 1);
    chk("clip_cnt_1", clip_count, 1);
    one("big2", 48'h1 << 40, 0, 7, 9999, 0, 255, 1);
    chk("clip_cnt_2", clip_count, 2);
    one("zero_negoff", 0, 1, 256, -100, 0, 0, 0);
    one("one_negoff", 1, 0, 256, 0, 0, 100, 0);
    one("frame_a", 1024, 1, 256, 2400, 0, 160, 0);
    chk("clip_cnt_clr", clip_count, 0);
    one("midframe_gain", 1024, 0, 128, 0, 0, 160, 0);
    one("frame_b", 1024, 1, 128, 1200, 0, 80, 0);
    base = nout;
    fork
      for (int i = 0; i < 20; i++)
        send(i == 4 ? 48'd0 : 48'(i * i * 37 + 1) << (i % 25), i % 8, i == 0, 300, 800, 1);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("stream_count", nout - base, 20);
    for (int i = 0; i < 3; i++) send(48'h1 << 40, 2, i == 0, 256, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_clip_count", clip_count, 0);
    repeat (6) @(posedge clk);
    #1 chk("midrst_no_output", out_valid, 0);
    one("default_cfg", 1024, 0, 999, 5, 1, 255, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
